noc_crossbar: RTL and testbench



---
 rtl/noc_params.sv | 45 ++++
 rtl/noc_crossbar.sv | 82 ++++++++
 tb/tb_noc_crossbar.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// noc_params: shared NoC type definitions.
//
// flit_t is the unit moved by the router data path: a two-bit label followed
// by a payload union that is read as a head layout (routing fields plus head
// payload) or as a body/tail layout (virtual channel plus raw payload). Both
// union members have the same width, so the union can be copied as plain bits.

package noc_params;

  localparam int VC_SIZE           = 4;
  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  localparam int HEAD_PAYLOAD_SIZE = 16;
  localparam int BODY_PAYLOAD_SIZE = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    logic [VC_SIZE-1:0]           vc_id;
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef struct packed {
    logic [VC_SIZE-1:0]           vc_id;
    logic [BODY_PAYLOAD_SIZE-1:0] bt_pl;
  } body_data_t;

  typedef union packed {
    head_data_t head_data;
    body_data_t bt_data;
  } flit_data_t;

  typedef struct packed {
    flit_label_t flit_label;
    flit_data_t  data;
  } flit_t;

endpackage

// File: rtl/noc_crossbar.sv
// noc_crossbar: flit switching fabric of the NoC router.
//
// Every output port k forwards input port sel_i[k]; the whole flit (label and
// payload union) is copied bit-exact. Outputs are independent, so several
// outputs may pick the same input (broadcast) and unselected inputs are simply
// dropped. A select that points past the last input (only reachable when
// INPUT_NUM is not a power of two) yields the all-zero flit.
//
// Build option (macro CROSSBAR_OUT_REG_EN):
//   undefined - purely combinational, zero latency; clk and rst are unused.
//   defined   - data_o is registered: one cycle of latency, and data_o is
//               cleared asynchronously while rst is low.
//
// Parameters:
//   INPUT_NUM  - number of input ports (>= 2)
//   OUTPUT_NUM - number of output ports (>= 1)
//
// Ports:
//   clk    - clock, only used by the output register stage
//   rst    - asynchronous active-low reset, only used by the register stage
//   data_i - input flits, one per input port
//   sel_i  - source input index, one per output port
//   data_o - output flits, one per output port

module noc_crossbar
  import noc_params::*;
#(
  parameter int INPUT_NUM  = 4,
  parameter int OUTPUT_NUM = 4,
  localparam int SEL_SIZE  = $clog2(INPUT_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  flit_t               data_i [INPUT_NUM],
  input  logic [SEL_SIZE-1:0] sel_i  [OUTPUT_NUM],
  output flit_t               data_o [OUTPUT_NUM]
);

  flit_t mux_d [OUTPUT_NUM];

  // Compare-and-pick instead of direct indexing: a select with no matching
  // input leaves the zero default, which covers out-of-range selects.
  always_comb begin
    for (int k = 0; k < OUTPUT_NUM; k++) begin
      mux_d[k] = '0;
      for (int j = 0; j < INPUT_NUM; j++) begin
        if (sel_i[k] == SEL_SIZE'(j)) begin
          mux_d[k] = data_i[j];
        end
      end
    end
  end

`ifdef CROSSBAR_OUT_REG_EN

  flit_t data_q [OUTPUT_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < OUTPUT_NUM; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < OUTPUT_NUM; k++) begin
        data_q[k] <= mux_d[k];
      end
    end
  end

  assign data_o = data_q;

`else

  assign data_o = mux_d;

  // clk and rst only exist for the registered build; tie them off here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

`endif

endmodule

// File: tb/tb_noc_crossbar.sv
// Self-checking bench for noc_crossbar. Works for both builds: with
// CROSSBAR_OUT_REG_EN defined, outputs are compared one clock edge after the
// stimulus and the reset/latency scenarios are exercised as well.

module tb_noc_crossbar;
  import noc_params::*;

  localparam int IN4    = 4;
  localparam int OUT4   = 4;
  localparam int IN3    = 3;
  localparam int OUT3   = 2;
  localparam int FLIT_W = $bits(flit_t);

  logic  clk = 1'b0;
  logic  rst = 1'b0;

  flit_t      d4 [IN4];
  logic [1:0] s4 [OUT4];
  flit_t      o4 [OUT4];

  flit_t      d3 [IN3];
  logic [1:0] s3 [OUT3];
  flit_t      o3 [OUT3];

  flit_t exp_q [$];
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  noc_crossbar #(.INPUT_NUM(IN4), .OUTPUT_NUM(OUT4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .data_i (d4),
    .sel_i  (s4),
    .data_o (o4)
  );

  noc_crossbar #(.INPUT_NUM(IN3), .OUTPUT_NUM(OUT3)) dut3 (
    .clk    (clk),
    .rst    (rst),
    .data_i (d3),
    .sel_i  (s3),
    .data_o (o3)
  );

  function automatic flit_t mk_head(input logic [3:0] v);
    flit_t f;
    f = '0;
    f.flit_label             = HEAD;
    f.data.head_data.vc_id   = v;
    f.data.head_data.x_dest  = v;
    f.data.head_data.y_dest  = v;
    f.data.head_data.head_pl = 16'(v);
    return f;
  endfunction

  function automatic flit_t rnd_flit();
    return flit_t'(FLIT_W'($urandom));
  endfunction

  // Let the DUT produce the result of the stimulus just driven.
  task automatic settle();
`ifdef CROSSBAR_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  // Expected value of each 4x4 output from the mux rule.
  task automatic push4();
    for (int k = 0; k < OUT4; k++) exp_q.push_back(d4[int'(s4[k])]);
  endtask

  task automatic push3();
    for (int k = 0; k < OUT3; k++) begin
      if (int'(s3[k]) < IN3) exp_q.push_back(d3[int'(s3[k])]);
      else                   exp_q.push_back('0);
    end
  endtask

  task automatic test_reset();
    flit_t e;
    for (int i = 0; i < IN4; i++) d4[i] = mk_head(4'(i + 3));
    for (int k = 0; k < OUT4; k++) s4[k] = 2'(k);
    for (int i = 0; i < IN3; i++) d3[i] = mk_head(4'(i + 9));
    for (int k = 0; k < OUT3; k++) s3[k] = 2'(k);
    repeat (3) @(posedge clk);
    #1;
`ifdef CROSSBAR_OUT_REG_EN
    for (int k = 0; k < OUT4; k++) exp_q.push_back('0);
`else
    push4();
`endif
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL reset_hold out%0d: got %h want %h", k, o4[k], e);
      else passes++;
    end
    rst = 1'b1;
    #1;
`ifdef CROSSBAR_OUT_REG_EN
    // Released but no edge yet: still zero.
    for (int k = 0; k < OUT4; k++) begin
      checks++;
      if (o4[k] !== flit_t'('0)) $display("FAIL reset_release_noedge out%0d: got %h want 0", k, o4[k]);
      else passes++;
    end
`endif
    settle();
    push4();
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL reset_first_valid out%0d: got %h want %h", k, o4[k], e);
      else passes++;
    end
  endtask

  task automatic test_identity();
    flit_t e;
    for (int j = 0; j < IN4; j++) begin
      for (int i = 0; i < IN4; i++) d4[i] = (i == j) ? mk_head(4'd1) : mk_head(4'd10);
      for (int k = 0; k < OUT4; k++) s4[k] = 2'(k);
      push4();
      settle();
      for (int k = 0; k < OUT4; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (o4[k] !== e) $display("FAIL identity j%0d out%0d: got %h want %h", j, k, o4[k], e);
        else passes++;
      end
      checks++;
      if (o4[j].data.head_data.head_pl !== 16'd1)
        $display("FAIL identity_pl j%0d: got %0d want 1", j, o4[j].data.head_data.head_pl);
      else passes++;
    end
  endtask

  task automatic test_permutation();
    flit_t e;
    for (int i = 0; i < IN4; i++) d4[i] = mk_head(4'(i));
    for (int k = 0; k < OUT4; k++) s4[k] = 2'(3 - k);
    push4();
    settle();
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL permutation out%0d: got %h want %h", k, o4[k], e);
      else passes++;
      checks++;
      if (o4[k].data.head_data.head_pl !== 16'(3 - k))
        $display("FAIL permutation_pl out%0d: got %0d want %0d", k, o4[k].data.head_data.head_pl, 3 - k);
      else passes++;
    end
  endtask

  task automatic test_broadcast();
    flit_t e;
    for (int i = 0; i < IN4; i++) d4[i] = rnd_flit();
    d4[2] = mk_head(4'd7);
    for (int k = 0; k < OUT4; k++) s4[k] = 2'd2;
    push4();
    settle();
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL broadcast out%0d: got %h want %h", k, o4[k], e);
      else passes++;
      checks++;
      if (o4[k].data.head_data.head_pl !== 16'd7)
        $display("FAIL broadcast_pl out%0d: got %0d want 7", k, o4[k].data.head_data.head_pl);
      else passes++;
    end
  endtask

  task automatic test_out_of_range();
    flit_t e;
    for (int i = 0; i < IN3; i++) d3[i] = mk_head(4'(i + 5));
    s3[0] = 2'd3;
    s3[1] = 2'd2;
    push3();
    settle();
    for (int k = 0; k < OUT3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o3[k] !== e) $display("FAIL out_of_range out%0d: got %h want %h", k, o3[k], e);
      else passes++;
    end
    checks++;
    if (o3[0] !== flit_t'('0)) $display("FAIL out_of_range_zero: got %h want 0", o3[0]);
    else passes++;
  endtask

  task automatic test_random();
    flit_t e;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < IN4; i++) d4[i] = rnd_flit();
      for (int k = 0; k < OUT4; k++) s4[k] = 2'($urandom_range(0, 3));
      for (int i = 0; i < IN3; i++) d3[i] = rnd_flit();
      for (int k = 0; k < OUT3; k++) s3[k] = 2'($urandom_range(0, 3));
      push4();
      push3();
      settle();
      for (int k = 0; k < OUT4; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (o4[k] !== e) $display("FAIL random4 n%0d out%0d: got %h want %h", n, k, o4[k], e);
        else passes++;
      end
      for (int k = 0; k < OUT3; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (o3[k] !== e) $display("FAIL random3 n%0d out%0d: got %h want %h", n, k, o3[k], e);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    flit_t e;
    for (int i = 0; i < IN4; i++) d4[i] = mk_head(4'(i + 1));
    for (int k = 0; k < OUT4; k++) s4[k] = 2'(k);
    push4();
    settle();
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL b2b_first out%0d: got %h want %h", k, o4[k], e);
      else passes++;
    end
    // Select change; registered build must hold the old value until the edge.
`ifdef CROSSBAR_OUT_REG_EN
    push4();
`endif
    for (int k = 0; k < OUT4; k++) s4[k] = 2'(k ^ 1);
`ifndef CROSSBAR_OUT_REG_EN
    push4();
`endif
    #2;
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL b2b_before_edge out%0d: got %h want %h", k, o4[k], e);
      else passes++;
    end
    push4();
    settle();
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL b2b_after_edge out%0d: got %h want %h", k, o4[k], e);
      else passes++;
    end
`ifdef CROSSBAR_OUT_REG_EN
    // Mid-run reset clears outputs with no clock edge in between.
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < OUT4; k++) begin
      checks++;
      if (o4[k] !== flit_t'('0)) $display("FAIL midrun_reset out%0d: got %h want 0", k, o4[k]);
      else passes++;
    end
    for (int k = 0; k < OUT3; k++) begin
      checks++;
      if (o3[k] !== flit_t'('0)) $display("FAIL midrun_reset3 out%0d: got %h want 0", k, o3[k]);
      else passes++;
    end
    @(negedge clk);
    rst = 1'b1;
    push4();
    settle();
    for (int k = 0; k < OUT4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o4[k] !== e) $display("FAIL midrun_recover out%0d: got %h want %h", k, o4[k], e);
      else passes++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_identity();
    test_permutation();
    test_broadcast();
    test_out_of_range();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
